// File: rtl/alsu_gen.sv
// Parametrised handshaked ALSU: logic/arith/shift ops in one cycle, iterative shift-add
// multiplier, and a blinking LED indicator for illegal opcode/reduction combinations.
module alsu_gen #(
    parameter int    WIDTH          = 8,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 direction,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic [2:0]           opcode,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic [15:0]          leds
);
    localparam int OW      = 2 * WIDTH;
    localparam int SW      = WIDTH + 1;
    localparam int CW      = $clog2(WIDTH);
    localparam bit PRI_A   = (INPUT_PRIORITY == "A");
    localparam bit USE_CIN = (FULL_ADDER == "ON");

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_reg, state_next;
    logic [OW-1:0]      out_reg, out_next;
    logic               out_valid_reg, out_valid_next;
    logic               err_reg, err_next;
    logic [15:0]        leds_reg, leds_next;
    logic [OW-1:0]      acc_reg, acc_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [WIDTH-1:0]   mul_a_reg, mul_a_next;
    logic [WIDTH-1:0]   mul_b_reg, mul_b_next;

    logic               accept;
    logic               invalid;
    logic               use_red_a;
    logic [WIDTH-1:0]   bypass_val;
    logic [SW-1:0]      sum;
    logic [OW-1:0]      op_result;
    logic [OW-1:0]      addend;
    logic [OW-1:0]      acc_step;
    logic [OW-1:0]      shifted_a [WIDTH];

    // Precomputed A<<k for every multiplier step; the current step picks one by cnt.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            assign shifted_a[gi] = {{WIDTH{1'b0}}, mul_a_reg} << gi;
        end
    endgenerate

    assign accept     = in_valid && (state_reg == IDLE);
    assign invalid    = (opcode[2:1] == 2'b11) ||
                        ((red_op_A || red_op_B) && (opcode[2:1] != 2'b00));
    assign use_red_a  = red_op_A && (!red_op_B || PRI_A);
    assign bypass_val = (bypass_A && (!bypass_B || PRI_A)) ? A : B;
    assign sum        = {1'b0, A} + {1'b0, B} + SW'(USE_CIN ? cin : 1'b0);
    assign addend     = mul_b_reg[cnt_reg] ? shifted_a[cnt_reg] : '0;
    assign acc_step   = acc_reg + addend;

    always_comb begin
        op_result = '0;
        case (opcode)
            3'd0: begin
                if (use_red_a)     op_result = OW'(&A);
                else if (red_op_B) op_result = OW'(&B);
                else               op_result = OW'(A & B);
            end
            3'd1: begin
                if (use_red_a)     op_result = OW'(^A);
                else if (red_op_B) op_result = OW'(^B);
                else               op_result = OW'(A ^ B);
            end
            3'd2: op_result = OW'(sum);
            3'd4: op_result = direction ? OW'({A[WIDTH-2:0], serial_in})
                                        : OW'({serial_in, A[WIDTH-1:1]});
            3'd5: op_result = direction ? OW'({A[WIDTH-2:0], A[WIDTH-1]})
                                        : OW'({A[0], A[WIDTH-1:1]});
            default: op_result = '0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        out_next       = out_reg;
        out_valid_next = 1'b0;
        err_next       = err_reg;
        leds_next      = err_reg ? ~leds_reg : leds_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        mul_a_next     = mul_a_reg;
        mul_b_next     = mul_b_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    // Any accept that is not invalid clears the error indicator.
                    err_next  = 1'b0;
                    leds_next = '0;
                    if (bypass_A || bypass_B) begin
                        out_next       = OW'(bypass_val);
                        out_valid_next = 1'b1;
                    end else if (invalid) begin
                        out_next       = '0;
                        out_valid_next = 1'b1;
                        err_next       = 1'b1;
                        leds_next      = 16'hFFFF;
                    end else if (opcode == 3'd3) begin
                        state_next = MUL;
                        mul_a_next = A;
                        mul_b_next = B;
                        acc_next   = '0;
                        cnt_next   = '0;
                    end else begin
                        out_next       = op_result;
                        out_valid_next = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_next = acc_step;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    out_next       = acc_step;
                    out_valid_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            leds_reg      <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            mul_a_reg     <= '0;
            mul_b_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            err_reg       <= err_next;
            leds_reg      <= leds_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            mul_a_reg     <= mul_a_next;
            mul_b_reg     <= mul_b_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign leds      = leds_reg;
endmodule

// File: tb/tb_alsu_gen.sv
// Directed-vector bench for alsu_gen (WIDTH=8, priority A, full adder on).
module tb_alsu_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  A, B;
    logic        cin, serial_in, direction;
    logic        red_op_A, red_op_B;
    logic [2:0]  opcode;
    logic        bypass_A, bypass_B;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic [15:0] leds;

    int checks = 0;
    int errors = 0;

    alsu_gen #(.WIDTH(8), .INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin), .serial_in(serial_in),
        .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .opcode(opcode), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .in_valid(in_valid), .in_ready(in_ready), .out(out),
        .out_valid(out_valid), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        opcode    = op;
        A         = a;
        B         = b;
        cin       = 1'b0;
        serial_in = 1'b0;
        direction = 1'b0;
        red_op_A  = 1'b0;
        red_op_B  = 1'b0;
        bypass_A  = 1'b0;
        bypass_B  = 1'b0;
        in_valid  = 1'b1;
    endtask

    // Fire the staged transaction and check a single-cycle result.
    task automatic fire_single(input string tag, input logic [15:0] exp);
        tick();
        in_valid = 1'b0;
        chk({tag, "_out"}, 32'(out), 32'(exp));
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        // Reset with random inputs driven
        rst       = 1'b0;
        A         = 8'($urandom);
        B         = 8'($urandom);
        cin       = 1'($urandom);
        serial_in = 1'($urandom);
        direction = 1'($urandom);
        red_op_A  = 1'($urandom);
        red_op_B  = 1'($urandom);
        opcode    = 3'($urandom);
        bypass_A  = 1'($urandom);
        bypass_B  = 1'($urandom);
        in_valid  = 1'b1;
        tick();
        tick();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_vld", 32'(out_valid), 32'h0);
        chk("rst_rdy", 32'(in_ready), 32'h1);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        chk("idle_vld", 32'(out_valid), 32'h0);

        // ADD with carry-in
        set_op(3'd2, 8'hFF, 8'h01);
        cin = 1'b1;
        fire_single("add_cin", 16'h0101);
        tick();
        chk("add_pulse", 32'(out_valid), 32'h0);
        chk("add_hold", 32'(out), 32'h0101);

        set_op(3'd2, 8'h80, 8'h80);
        fire_single("add_carry", 16'h0100);

        // MULT FF*FF
        set_op(3'd3, 8'hFF, 8'hFF);
        tick();
        in_valid = 1'b0;
        chk("mul_rdy0", 32'(in_ready), 32'h0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("mul_rdy", 32'(in_ready), 32'h0);
            chk("mul_novld", 32'(out_valid), 32'h0);
        end
        tick();
        chk("mul_out", 32'(out), 32'hFE01);
        chk("mul_vld", 32'(out_valid), 32'h1);
        chk("mul_rdy1", 32'(in_ready), 32'h1);
        tick();
        chk("mul_pulse", 32'(out_valid), 32'h0);

        // Invalid opcode and LED blink
        set_op(3'd6, 8'h55, 8'hAA);
        fire_single("inv6", 16'h0000);
        chk("inv_leds0", 32'(leds), 32'hFFFF);
        tick();
        chk("inv_leds1", 32'(leds), 32'h0000);
        tick();
        chk("inv_leds2", 32'(leds), 32'hFFFF);
        tick();
        chk("inv_leds3", 32'(leds), 32'h0000);

        // AND clears the error
        set_op(3'd0, 8'hF0, 8'h3C);
        fire_single("and", 16'h0030);
        chk("and_leds", 32'(leds), 32'h0000);
        tick();
        chk("and_leds2", 32'(leds), 32'h0000);

        set_op(3'd1, 8'hF0, 8'h3C);
        fire_single("xor", 16'h00CC);

        // Reduction with a non-logic opcode is invalid
        set_op(3'd2, 8'h01, 8'h01);
        red_op_A = 1'b1;
        fire_single("red_inv", 16'h0000);
        chk("red_inv_leds", 32'(leds), 32'hFFFF);

        // Bypass beats invalid; both bypass -> A wins; clears error
        set_op(3'd7, 8'h12, 8'h34);
        bypass_A = 1'b1;
        bypass_B = 1'b1;
        fire_single("bypass", 16'h0012);
        chk("bypass_leds", 32'(leds), 32'h0000);

        set_op(3'd0, 8'h00, 8'h34);
        bypass_B = 1'b1;
        fire_single("bypass_b", 16'h0034);

        // Reductions
        set_op(3'd1, 8'h07, 8'h03);
        red_op_A = 1'b1;
        red_op_B = 1'b1;
        fire_single("red_xor_a", 16'h0001);

        set_op(3'd0, 8'h7F, 8'hFF);
        red_op_B = 1'b1;
        fire_single("red_and_b", 16'h0001);

        // Shift / rotate
        set_op(3'd4, 8'h81, 8'h00);
        direction = 1'b1;
        fire_single("shl", 16'h0002);

        set_op(3'd4, 8'h81, 8'h00);
        serial_in = 1'b1;
        fire_single("shr", 16'h00C0);

        set_op(3'd5, 8'h01, 8'h00);
        fire_single("ror", 16'h0080);

        set_op(3'd5, 8'h80, 8'h00);
        direction = 1'b1;
        fire_single("rol", 16'h0001);

        // Reset in the middle of a multiply
        set_op(3'd3, 8'h03, 8'h05);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_out", 32'(out), 32'h0);
        chk("abort_vld", 32'(out_valid), 32'h0);
        chk("abort_rdy", 32'(in_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_novld", 32'(out_valid), 32'h0);
        end

        // Multiplier works again after the abort; bounded wait for the result
        set_op(3'd3, 8'h03, 8'h05);
        tick();
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("mul2_lat", 32'(n), 32'd8);
        end
        chk("mul2_out", 32'(out), 32'h000F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
